// File: rtl/crc8_pkg.sv
// Shared types and constants for the CRC-8 framing controller and its serial core.
package crc8_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SHIFT     = 2'd1,
    ST_SEND_DATA = 2'd2,
    ST_SEND_CRC  = 2'd3
  } state_e;

  localparam logic [7:0] CRC8_POLY_ATM     = 8'h07;
  localparam logic [7:0] CRC8_INIT_DEFAULT = 8'h00;

  // One MSB-first CRC step: shift left, fold in the polynomial when the outgoing bit differs.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in,
                                           input logic [7:0] poly);
    return {crc[6:0], 1'b0} ^ (((bit_in ^ crc[7]) == 1'b1) ? poly : 8'h00);
  endfunction

endpackage

// File: rtl/crc8_frame_ctrl_if.sv
// Byte-stream handshake bundle between the packet source/sink and the framing controller.
interface crc8_frame_ctrl_if;
  logic       abort;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;

  modport master (
    output abort, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy
  );

  modport slave (
    input  abort, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/crc8_serial_core.sv
// Bit-serial CRC-8 register; clear takes priority over the shift enable.
module crc8_serial_core
  import crc8_pkg::*;
#(
  parameter logic [7:0] POLY = CRC8_POLY_ATM,
  parameter logic [7:0] INIT = CRC8_INIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [7:0] crc
);

  logic [7:0] r_crc;

  // CRC register: clear, else one update per enabled bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc <= INIT;
    end else if (clr) begin
      r_crc <= INIT;
    end else if (en) begin
      r_crc <= crc8_step(r_crc, bit_in, POLY);
    end
  end

  assign crc = r_crc;

endmodule

// File: rtl/crc8_frame_ctrl.sv
// Framing controller: serialises each accepted byte into the CRC core, echoes it,
// and appends the accumulated CRC after the last byte of a frame.
module crc8_frame_ctrl
  import crc8_pkg::*;
#(
  parameter logic [7:0] POLY = CRC8_POLY_ATM,
  parameter logic [7:0] INIT = CRC8_INIT_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  crc8_frame_ctrl_if.slave   bus
);

  state_e     r_state;
  state_e     w_next_state;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_byte;
  logic       r_last;
  logic [7:0] w_crc;
  logic       w_core_clr;
  logic       w_core_en;
  logic       w_core_bit;
  logic       w_accept;

  assign w_accept = (r_state == ST_IDLE) && bus.in_valid && !bus.abort;

  crc8_serial_core #(
    .POLY (POLY),
    .INIT (INIT)
  ) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (w_core_clr),
    .en     (w_core_en),
    .bit_in (w_core_bit),
    .crc    (w_crc)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and core sequencing; abort overrides every state and clears the CRC
  always_comb begin
    w_next_state = r_state;
    w_core_clr   = 1'b0;
    w_core_en    = 1'b0;
    w_core_bit   = 1'b0;
    if (bus.abort) begin
      w_next_state = ST_IDLE;
      w_core_clr   = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            w_next_state = ST_SHIFT;
          end else begin
            w_next_state = ST_IDLE;
          end
        end
        ST_SHIFT: begin
          w_core_en  = 1'b1;
          w_core_bit = r_byte[r_bit_cnt];
          if (r_bit_cnt == 3'd0) begin
            w_next_state = ST_SEND_DATA;
          end else begin
            w_next_state = ST_SHIFT;
          end
        end
        ST_SEND_DATA: begin
          if (bus.out_ready) begin
            w_next_state = r_last ? ST_SEND_CRC : ST_IDLE;
          end else begin
            w_next_state = ST_SEND_DATA;
          end
        end
        ST_SEND_CRC: begin
          if (bus.out_ready) begin
            w_core_clr   = 1'b1;
            w_next_state = ST_IDLE;
          end else begin
            w_next_state = ST_SEND_CRC;
          end
        end
        default: begin
          w_next_state = ST_IDLE;
        end
      endcase
    end
  end

  // Byte capture and MSB-first bit counter; abort discards the held byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte    <= 8'h00;
      r_last    <= 1'b0;
      r_bit_cnt <= 3'd0;
    end else if (bus.abort) begin
      r_byte    <= 8'h00;
      r_last    <= 1'b0;
      r_bit_cnt <= 3'd0;
    end else if (w_accept) begin
      r_byte    <= bus.in_data;
      r_last    <= bus.in_last;
      r_bit_cnt <= 3'd7;
    end else if ((r_state == ST_SHIFT) && (r_bit_cnt != 3'd0)) begin
      r_bit_cnt <= r_bit_cnt - 3'd1;
    end
  end

  // Output muxing straight from registered state, byte and CRC
  always_comb begin
    bus.in_ready  = (r_state == ST_IDLE) && !bus.abort;
    bus.out_valid = (r_state == ST_SEND_DATA) || (r_state == ST_SEND_CRC);
    bus.out_last  = (r_state == ST_SEND_CRC);
    bus.busy      = (r_state != ST_IDLE);
    if (r_state == ST_SEND_CRC) begin
      bus.out_data = w_crc;
    end else begin
      bus.out_data = r_byte;
    end
  end

endmodule

// File: doc/crc8_frame_ctrl.md
# crc8_frame_ctrl

Byte-stream framing controller around a serial CRC-8 engine. It accepts bytes over a valid/ready input and feeds each byte MSB-first, one bit per clock, into the serial CRC core. It forwards each byte downstream and appends the computed CRC byte after the last byte of every frame. It sits between the packet source and the serial line transmitter and owns the CRC register's clear and enable sequencing.

## Interface
- POLY, 8'h07, CRC polynomial without the x^8 term (CRC-8-ATM: x^8+x^2+x+1)
- INIT, 8'h00, CRC register value at reset, on clear, and at frame start
- clk  in  1  clock; all logic is rising-edge
- rst_n  in  1  reset: asynchronous, active-low
- abort  in  1  synchronous frame abort; highest priority after reset
- in_valid  in  1  input byte valid
- in_ready  out  1  controller can accept a byte
- in_data  in  8  input byte
- in_last  in  1  marks the final byte of a frame; qualified by in_valid
- out_valid  out  1  output byte valid
- out_ready  in  1  downstream accepts the output byte
- out_data  out  8  output byte: a data byte, or the CRC in the CRC slot
- out_last  out  1  high only on the CRC byte
- busy  out  1  high when the state is not IDLE

## Operation
- States: IDLE, SHIFT, SEND_DATA, SEND_CRC.
- IDLE: in_ready=1.
  - On in_valid&in_ready, capture in_data into byte_reg and in_last into last_reg.
  - Set bit_cnt=7 and go to SHIFT.
- SHIFT: in_ready=0.
  - Each cycle, drive core en=1 with bit_in=byte_reg[bit_cnt], so bit 7 goes first.
  - Decrement bit_cnt. Wrap-around is not used.
  - When bit_cnt==0 (8th bit), go to SEND_DATA.
- SEND_DATA: out_valid=1, out_data=byte_reg, out_last=0.
  - On out_ready, go to SEND_CRC if last_reg=1, otherwise go to IDLE.
- SEND_CRC: out_valid=1, out_data=crc, out_last=1.
  - On out_ready, pulse core clr (crc returns to INIT) and go to IDLE.
- CRC update per enabled bit: crc <= {crc[6:0],0} ^ ((bit_in ^ crc[7]) ? POLY : 0). No reflection, no final XOR.
- The CRC accumulates across all bytes of a frame. It is cleared only by reset, by the SEND_CRC handshake, or by abort.
- Output stability: while out_valid=1 and out_ready=0, out_data and out_last hold constant. out_valid never drops without a handshake, except on abort or reset.
- abort=1 in any state:
  - Next state is IDLE and the core is cleared.
  - byte_reg is discarded, no output is produced, and out_valid is 0 the next cycle.
  - In IDLE, abort also blocks acceptance: in_ready=0 while abort=1.
- A single-byte frame (in_last on the first byte) produces the data byte followed by the CRC byte.
- in_valid while not IDLE is ignored (in_ready=0). The source must hold the byte.

## Timing
- Reset values:
  - state=IDLE, crc=INIT, bit_cnt=0, byte_reg=0, last_reg=0
  - in_ready=1, out_valid=0, out_data=0, out_last=0, busy=0
- Accept handshake at edge T:
  - SHIFT occupies cycles T+1..T+8 (8 core updates).
  - out_valid rises in cycle T+9.
- With out_ready held high, a non-last byte returns to IDLE at T+10, giving 10 cycles per byte.
- With out_ready held high, a last byte presents CRC in T+10 and reaches IDLE at T+11.
- The CRC presented in SEND_CRC includes all 8 bits of the last byte. No extra pipeline stage is needed.
- Backpressure stretches SEND_DATA/SEND_CRC indefinitely. The CRC does not change there (en=0).
- If reset is asserted mid-operation, all outputs take reset values immediately (asynchronously). The partial frame is lost.

## Structure
- Package crc8_pkg:
  - state enum (IDLE, SHIFT, SEND_DATA, SEND_CRC)
  - CRC8_POLY_ATM=8'h07
  - CRC8_INIT_DEFAULT=8'h00
- Sub-module crc8_serial_core:
  - ports: clk, rst_n, clr, en, bit_in, crc[7:0]
  - parameters: POLY, INIT
  - clr has priority over en.
- The controller owns the FSM, bit_cnt, byte_reg/last_reg and the output muxing.

## Test plan
- Single byte 0x01 with in_last, out_ready=1:
  - outputs 0x01 (last=0), then 0x07 (last=1)
  - out_valid first high 9 cycles after accept
- Single byte 0xFF with last → 0xFF, then 0xF3. Single byte 0x80 with last → 0x80, then 0x89.
- Frame ASCII "123456789" (0x31..0x39, last on 0x39):
  - all 9 bytes echoed in order, then 0xF4 with out_last=1
  - second identical frame also ends in 0xF4, which checks the clear
- Backpressure: hold out_ready=0 for 5 cycles in SEND_DATA and in SEND_CRC:
  - out_data/out_last stable and CRC unchanged
  - in_ready=0 throughout
  - correct bytes once released
- Abort asserted during SHIFT of byte 2 of a frame, then frame 0x01+last:
  - nothing output for the aborted frame
  - next frame yields 0x01, 0x07
- Async reset asserted in SEND_CRC: out_valid=0 and in_ready=1 immediately; the next frame's CRC starts from 0x00.
